// File: rtl/johnson_count_monitor.sv
// johnson_count_monitor: registers a raw N-bit Johnson count, decodes it to a
// binary index and checks that every change is one forward Johnson step.
// Stage 1 captures the raw count. Stage 2 compares it with the previous
// sample and updates the index, step, wraps and error outputs.
module johnson_count_monitor #(
  parameter int N      = 10,
  parameter int WRAP_W = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      count,
  input  logic              clear_err,
  output logic [$clog2(2*N)-1:0] index,
  output logic              index_valid,
  output logic              step,
  output logic [WRAP_W-1:0] wraps,
  output logic              err_code,
  output logic              err_step,
  output logic [ERR_W-1:0]  err_count
);
  localparam int IW = $clog2(2*N);
  localparam logic [IW-1:0] LAST_IDX = IW'(2*N-1);

  // A legal code is a run of ones anchored at bit 0 (MSB clear) or a run of
  // ones anchored at bit N-1 (MSB set). Inverting the MSB-set form turns it
  // into the first form, so one "low ones only" test covers both.
  function automatic logic is_legal(input logic [N-1:0] c);
    logic [N-1:0] x;
    x = c[N-1] ? ~c : c;
    return (x & (x + N'(1))) == '0;
  endfunction

  function automatic logic [IW-1:0] decode(input logic [N-1:0] c);
    int pc;
    pc = 0;
    for (int i = 0; i < N; i++) pc += int'(c[i]);
    return c[N-1] ? IW'(2*N - pc) : IW'(pc);
  endfunction

  logic [N-1:0]      cur_q, cur_d, prev_q, prev_d;
  logic              in_vld_q, in_vld_d;
  logic              primed_q, primed_d;
  logic [IW-1:0]     index_q, index_d;
  logic              index_valid_q, index_valid_d;
  logic              step_q, step_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              err_code_q, err_code_d;
  logic              err_step_q, err_step_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  logic          cur_leg, prev_leg, code_hit, step_hit;
  logic [IW-1:0] idx_cur, idx_prev, idx_next;
  logic [ERR_W-1:0] cnt_base;

  assign cur_leg  = is_legal(cur_q);
  assign prev_leg = is_legal(prev_q);
  assign idx_cur  = decode(cur_q);
  assign idx_prev = decode(prev_q);
  assign idx_next = (idx_prev == LAST_IDX) ? '0 : idx_prev + IW'(1);

  // Next-state: sample capture, transition classification, error bookkeeping.
  always_comb begin
    cur_d         = count;
    in_vld_d      = 1'b1;   // cur_q holds a real sample from the 1st edge on
    prev_d        = prev_q;
    primed_d      = primed_q;
    index_d       = index_q;
    index_valid_d = index_valid_q;
    step_d        = 1'b0;
    wraps_d       = wraps_q;
    code_hit      = 1'b0;
    step_hit      = 1'b0;

    if (in_vld_q) begin
      prev_d   = cur_q;
      primed_d = 1'b1;
      if (!primed_q) begin
        // First sample after reset: no history, so only legality matters.
        index_valid_d = cur_leg;
        if (cur_leg) index_d = idx_cur;
        else         code_hit = 1'b1;
      end else if (cur_q == prev_q) begin
        index_valid_d = cur_leg;
      end else if (cur_leg && prev_leg) begin
        index_d       = idx_cur;
        index_valid_d = 1'b1;
        if (idx_cur == idx_next) begin
          step_d = 1'b1;
          if (idx_prev == LAST_IDX) wraps_d = wraps_q + WRAP_W'(1);
        end else begin
          step_hit = 1'b1;
        end
      end else if (!cur_leg) begin
        code_hit      = 1'b1;
        index_valid_d = 1'b0;
      end else begin
        // Coming back from an illegal code: resynchronise silently.
        index_d       = idx_cur;
        index_valid_d = 1'b1;
      end
    end

    // Clear first, then let a same-cycle error win.
    err_code_d  = clear_err ? 1'b0 : err_code_q;
    err_step_d  = clear_err ? 1'b0 : err_step_q;
    cnt_base    = clear_err ? '0 : err_count_q;
    err_count_d = cnt_base;
    if (code_hit) err_code_d = 1'b1;
    if (step_hit) err_step_d = 1'b1;
    if ((code_hit || step_hit) && (cnt_base != '1)) err_count_d = cnt_base + ERR_W'(1);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q         <= '0;
      prev_q        <= '0;
      in_vld_q      <= 1'b0;
      primed_q      <= 1'b0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      step_q        <= 1'b0;
      wraps_q       <= '0;
      err_code_q    <= 1'b0;
      err_step_q    <= 1'b0;
      err_count_q   <= '0;
    end else begin
      cur_q         <= cur_d;
      prev_q        <= prev_d;
      in_vld_q      <= in_vld_d;
      primed_q      <= primed_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      step_q        <= step_d;
      wraps_q       <= wraps_d;
      err_code_q    <= err_code_d;
      err_step_q    <= err_step_d;
      err_count_q   <= err_count_d;
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign step        = step_q;
  assign wraps       = wraps_q;
  assign err_code    = err_code_q;
  assign err_step    = err_step_q;
  assign err_count   = err_count_q;
endmodule

// File: tb/tb_johnson_count_monitor.sv
// Directed bench for johnson_count_monitor (N=10): walk, backward/skip,
// illegal/resync, saturation, clear_err and mid-walk reset.
module tb_johnson_count_monitor;
  logic        clk, reset, clear_err;
  logic [9:0]  count;
  logic [4:0]  index;
  logic        index_valid, step, err_code, err_step;
  logic [15:0] wraps;
  logic [7:0]  err_count;

  int vecs  = 0;
  int fails = 0;
  int steps = 0;

  johnson_count_monitor #(.N(10), .WRAP_W(16), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .count(count), .clear_err(clear_err),
    .index(index), .index_valid(index_valid), .step(step), .wraps(wraps),
    .err_code(err_code), .err_step(err_step), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-derived N=10 Johnson sequence: index i -> code.
  function automatic logic [9:0] code_of(input int i);
    logic [9:0] all1;
    all1 = 10'h3FF;
    if (i <= 10) return 10'((1 << i) - 1);
    return all1 ^ 10'((1 << (i - 10)) - 1);
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_index"}, 32'(index), 32'd0);
    chk({tag, "_valid"}, 32'(index_valid), 32'd0);
    chk({tag, "_step"}, 32'(step), 32'd0);
    chk({tag, "_wraps"}, 32'(wraps), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_err_step"}, 32'(err_step), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; count = '0; clear_err = 1'b0;
    tick(); tick();
    chk_reset_state("rst");
    reset = 1'b0;
    tick();
    chk("prime_wait_valid", 32'(index_valid), 32'd0);
    tick();
    chk("prime_valid", 32'(index_valid), 32'd1);
    chk("prime_index", 32'(index), 32'd0);
    chk("prime_step", 32'(step), 32'd0);
    tick();
    chk("hold0_step", 32'(step), 32'd0);
    chk("hold0_err", 32'(err_count), 32'd0);

    // Full walk 1..19,0: one step pulse per cycle, one wrap.
    count = code_of(1);
    tick();
    for (int k = 2; k <= 20; k++) begin
      count = code_of(k % 20);
      tick();
      chk($sformatf("walk_step_%0d", k - 1), 32'(step), 32'd1);
      chk($sformatf("walk_index_%0d", k - 1), 32'(index), 32'(k - 1));
      if (step) steps++;
    end
    tick();
    chk("walk_step_0", 32'(step), 32'd1);
    chk("walk_index_0", 32'(index), 32'd0);
    if (step) steps++;
    chk("walk_wraps", 32'(wraps), 32'd1);
    tick();
    chk("walk_hold_step", 32'(step), 32'd0);
    chk("walk_total_steps", 32'(steps), 32'd20);
    chk("walk_err_count", 32'(err_count), 32'd0);
    chk("walk_err_code", 32'(err_code), 32'd0);
    chk("walk_err_step", 32'(err_step), 32'd0);

    // Backward step 0x003 -> 0x001.
    count = 10'h001; tick();
    count = 10'h003; tick();
    count = 10'h001; tick(); tick();
    chk("back_err_step", 32'(err_step), 32'd1);
    chk("back_err_count", 32'(err_count), 32'd1);
    chk("back_index", 32'(index), 32'd1);
    chk("back_step", 32'(step), 32'd0);
    chk("back_valid", 32'(index_valid), 32'd1);
    // Skip 0x003 -> 0x00F.
    count = 10'h003; tick();
    count = 10'h00F; tick(); tick();
    chk("skip_err_count", 32'(err_count), 32'd2);
    chk("skip_index", 32'(index), 32'd4);
    chk("skip_step", 32'(step), 32'd0);

    // Return to 0x003 (a backward error), then clear_err alone.
    count = 10'h003; tick(); tick();
    chk("back2_err_count", 32'(err_count), 32'd3);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("clr1_err_count", 32'(err_count), 32'd0);
    chk("clr1_err_step", 32'(err_step), 32'd0);
    chk("clr1_index", 32'(index), 32'd2);

    // Illegal 0x005, then resync at 0x007.
    count = 10'h005; tick(); tick();
    chk("ill_err_code", 32'(err_code), 32'd1);
    chk("ill_valid", 32'(index_valid), 32'd0);
    chk("ill_index", 32'(index), 32'd2);
    chk("ill_err_count", 32'(err_count), 32'd1);
    count = 10'h007; tick(); tick();
    chk("resync_index", 32'(index), 32'd3);
    chk("resync_valid", 32'(index_valid), 32'd1);
    chk("resync_step", 32'(step), 32'd0);
    chk("resync_err_step", 32'(err_step), 32'd0);
    chk("resync_err_count", 32'(err_count), 32'd1);

    // 300 illegal changes saturate the counter.
    for (int i = 0; i < 300; i++) begin
      count = (i % 2 == 1) ? 10'h009 : 10'h005;
      tick();
    end
    tick(); tick();
    chk("sat_err_count", 32'(err_count), 32'd255);
    tick(); tick();
    chk("sat_hold", 32'(err_count), 32'd255);
    chk("sat_valid", 32'(index_valid), 32'd0);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("clr2_err_count", 32'(err_count), 32'd0);
    chk("clr2_err_code", 32'(err_code), 32'd0);
    chk("clr2_err_step", 32'(err_step), 32'd0);
    chk("clr2_wraps", 32'(wraps), 32'd1);
    // clear_err in the same cycle as a new illegal change: error wins.
    count = 10'h005; tick();
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("clrerr_err_count", 32'(err_count), 32'd1);
    chk("clrerr_err_code", 32'(err_code), 32'd1);

    // Resync at 0, walk to index 7, reset mid-walk.
    count = 10'h000; tick(); tick();
    chk("rs0_index", 32'(index), 32'd0);
    chk("rs0_valid", 32'(index_valid), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      count = code_of(k);
      tick();
    end
    tick();
    chk("mid_index", 32'(index), 32'd7);
    chk("mid_step", 32'(step), 32'd1);
    reset = 1'b1; tick();
    chk_reset_state("midrst");
    reset = 1'b0;
    count = 10'h07F; tick(); tick();
    chk("post_index", 32'(index), 32'd7);
    chk("post_valid", 32'(index_valid), 32'd1);
    chk("post_step", 32'(step), 32'd0);
    chk("post_err_step", 32'(err_step), 32'd0);
    chk("post_err_count", 32'(err_count), 32'd0);
    count = 10'h0FF; tick(); tick();
    chk("post2_step", 32'(step), 32'd1);
    chk("post2_index", 32'(index), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
